// File: rtl/keypad_scanner.sv
// 3x4 active-low key matrix scanner: prescaled row scan, frame-level debounce, one-cycle change strobe.
// Optional ghost-frame rejection is built when KEYPAD_GHOST_REJECT_EN is defined.
module keypad_scanner #(
  parameter int SCAN_DIV   = 50000,
  parameter int DB_SAMPLES = 4
) (
  input  logic        clk_raw,
  input  logic        rst,
  input  logic [3:0]  col_n,
  output logic [2:0]  row_n,
  output logic [11:0] keystroke,
  output logic        key_valid,
  output logic        any_key
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (DB_SAMPLES > 2) ? $clog2(DB_SAMPLES) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_SAMPLES - 1);

  typedef enum logic [1:0] {ROW0, ROW1, ROW2} row_e;

  row_e          state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    col_s1_q, col_s2_q;
  logic [11:0]   frame_q, frame_d;
  logic [11:0]   last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [11:0]   ks_q, ks_d;
  logic          kv_q, kv_d;
  logic          any_q, any_d;
  logic          tick, frame_done, ghost;
  logic [11:0]   frame_full;

  assign tick       = (presc_q == PRE_MAX);
  assign presc_d    = tick ? '0 : presc_q + PW'(1);
  assign frame_done = tick && (state_q == ROW2);
  // Row 2's nibble is merged here so the finished frame is usable on the same tick.
  assign frame_full = {~col_s2_q, frame_q[7:0]};

`ifdef KEYPAD_GHOST_REJECT_EN
  function automatic logic multi(input logic [3:0] x);
    return (x & (x - 4'd1)) != 4'd0;
  endfunction
  assign ghost = multi(frame_full[3:0] & frame_full[7:4])  |
                 multi(frame_full[3:0] & frame_full[11:8]) |
                 multi(frame_full[7:4] & frame_full[11:8]);
`else
  assign ghost = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    row_n   = 3'b110;
    frame_d = frame_q;
    case (state_q)
      ROW0: begin
        row_n = 3'b110;
        if (tick) begin
          state_d       = ROW1;
          frame_d[3:0]  = ~col_s2_q;
        end
      end
      ROW1: begin
        row_n = 3'b101;
        if (tick) begin
          state_d       = ROW2;
          frame_d[7:4]  = ~col_s2_q;
        end
      end
      ROW2: begin
        row_n = 3'b011;
        if (tick) begin
          state_d       = ROW0;
          frame_d[11:8] = ~col_s2_q;
        end
      end
      default: state_d = ROW0;
    endcase
  end

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    last_d = last_q;
    cnt_d  = cnt_q;
    ks_d   = ks_q;
    kv_d   = 1'b0;
    if (frame_done && !ghost) begin
      if (frame_full == last_q) begin
        cnt_d = cnt_inc;
        if (cnt_inc == CNT_MAX && last_q != ks_q) begin
          ks_d = last_q;
          kv_d = 1'b1;
        end
      end else begin
        last_d = frame_full;
        cnt_d  = '0;
      end
    end
    any_d = |ks_d;
  end

  always_ff @(posedge clk_raw or posedge rst) begin
    if (rst) begin
      state_q  <= ROW0;
      presc_q  <= '0;
      col_s1_q <= 4'b1111;
      col_s2_q <= 4'b1111;
      frame_q  <= '0;
      last_q   <= '0;
      cnt_q    <= '0;
      ks_q     <= '0;
      kv_q     <= 1'b0;
      any_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      col_s1_q <= col_n;
      col_s2_q <= col_s1_q;
      frame_q  <= frame_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      ks_q     <= ks_d;
      kv_q     <= kv_d;
      any_q    <= any_d;
    end
  end

  assign keystroke = ks_q;
  assign key_valid = kv_q;
  assign any_key   = any_q;

endmodule
